// File: rtl/m2_pkg.sv
// Shared types, constants and address helpers for the Milestone 2 IDCT block scheduler.
package m2_pkg;

  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned STRIDE_W  = 9;
  localparam int unsigned BROW_W    = 5;
  localparam int unsigned BCOL_W    = 6;
  localparam int unsigned COL_OFF_W = 9;
  localparam int unsigned BLK_IDX_W = 12;
  localparam int unsigned BLK_SHIFT = 3;

  localparam int unsigned Y_BLK_COLS  = 40;
  localparam int unsigned UV_BLK_COLS = 20;
  localparam int unsigned BLK_ROWS    = 30;
  localparam int unsigned NUM_BLOCKS  = (Y_BLK_COLS + 2 * UV_BLK_COLS) * BLK_ROWS;

  localparam int unsigned PRE_Y_BASE = 76800;
  localparam int unsigned PRE_U_BASE = 153600;
  localparam int unsigned PRE_V_BASE = 192000;
  localparam int unsigned OUT_Y_BASE = 0;
  localparam int unsigned OUT_U_BASE = 38400;
  localparam int unsigned OUT_V_BASE = 57600;

  localparam int unsigned PRE_Y_STRIDE  = 320;
  localparam int unsigned PRE_UV_STRIDE = 160;
  localparam int unsigned OUT_Y_STRIDE  = 160;
  localparam int unsigned OUT_UV_STRIDE = 80;
  localparam int unsigned PRE_COL_STEP  = 8;
  localparam int unsigned OUT_COL_STEP  = 4;

  // Worker unit bit positions in launch/done masks.
  localparam int unsigned NUM_UNITS = 4;
  localparam int unsigned U_FS = 0;
  localparam int unsigned U_CT = 1;
  localparam int unsigned U_CS = 2;
  localparam int unsigned U_WS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_FS,
    S_LEAD_CT,
    S_PH_B,
    S_PH_A,
    S_LEAD_OUT_WS,
    S_DONE
  } m2_state_e;

  typedef enum logic [1:0] {
    PL_Y,
    PL_U,
    PL_V
  } plane_e;

  function automatic logic [ADDR_W-1:0] plane_base(input plane_e plane, input logic out_side);
    logic [ADDR_W-1:0] base;
    base = '0;
    case (plane)
      PL_Y:    base = out_side ? ADDR_W'(OUT_Y_BASE) : ADDR_W'(PRE_Y_BASE);
      PL_U:    base = out_side ? ADDR_W'(OUT_U_BASE) : ADDR_W'(PRE_U_BASE);
      default: base = out_side ? ADDR_W'(OUT_V_BASE) : ADDR_W'(PRE_V_BASE);
    endcase
    return base;
  endfunction

  function automatic logic [STRIDE_W-1:0] row_stride(input plane_e plane, input logic out_side);
    logic [STRIDE_W-1:0] stride;
    if (plane == PL_Y) stride = out_side ? STRIDE_W'(OUT_Y_STRIDE)  : STRIDE_W'(PRE_Y_STRIDE);
    else               stride = out_side ? STRIDE_W'(OUT_UV_STRIDE) : STRIDE_W'(PRE_UV_STRIDE);
    return stride;
  endfunction

  // One block row spans eight word rows.
  function automatic logic [ADDR_W-1:0] row_step(input plane_e plane, input logic out_side);
    return ADDR_W'(row_stride(plane, out_side)) << BLK_SHIFT;
  endfunction

  function automatic logic [COL_OFF_W-1:0] col_step(input logic out_side);
    return out_side ? COL_OFF_W'(OUT_COL_STEP) : COL_OFF_W'(PRE_COL_STEP);
  endfunction

  function automatic logic [BCOL_W-1:0] plane_cols(input plane_e plane);
    return (plane == PL_Y) ? BCOL_W'(Y_BLK_COLS) : BCOL_W'(UV_BLK_COLS);
  endfunction

  function automatic plane_e next_plane(input plane_e plane);
    plane_e nxt;
    case (plane)
      PL_Y:    nxt = PL_U;
      PL_U:    nxt = PL_V;
      default: nxt = PL_Y;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/m2_block_addr_gen.sv
// Block walker: plane/row/column counters with running row-base and column-offset
// accumulators producing the SRAM address of the current block.
module m2_block_addr_gen
  import m2_pkg::*;
#(
  parameter bit OUT_SIDE = 1'b0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                clear,
  input  logic                advance,
  output logic [ADDR_W-1:0]   addr_c,
  output logic [STRIDE_W-1:0] stride_c
);

  plane_e               plane;
  logic [BROW_W-1:0]    brow;
  logic [BCOL_W-1:0]    bcol;
  logic [ADDR_W-1:0]    row_base;
  logic [COL_OFF_W-1:0] col_off;
  plane_e               plane_nxt_c;

  assign plane_nxt_c = next_plane(plane);

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      plane    <= PL_Y;
      brow     <= '0;
      bcol     <= '0;
      row_base <= plane_base(PL_Y, OUT_SIDE);
      col_off  <= '0;
    end else if (advance) begin
      if (bcol == plane_cols(plane) - BCOL_W'(1)) begin
        bcol    <= '0;
        col_off <= '0;
        if (brow == BROW_W'(BLK_ROWS - 1)) begin
          brow     <= '0;
          plane    <= plane_nxt_c;
          row_base <= plane_base(plane_nxt_c, OUT_SIDE);
        end else begin
          brow     <= brow + BROW_W'(1);
          row_base <= row_base + row_step(plane, OUT_SIDE);
        end
      end else begin
        bcol    <= bcol + BCOL_W'(1);
        col_off <= col_off + col_step(OUT_SIDE);
      end
    end
  end

  assign addr_c   = row_base + ADDR_W'(col_off);
  assign stride_c = row_stride(plane, OUT_SIDE);

endmodule

// File: rtl/m2_block_scheduler.sv
// Milestone 2 IDCT sequencer: walks all Y/U/V blocks, overlapping fetch/compute/write
// in two alternating phases, and owns the block addresses and SRAM port select.
module m2_block_scheduler
  import m2_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  output logic                Busy,
  output logic                Done,
  output logic                fetch_start,
  output logic [ADDR_W-1:0]   fetch_addr,
  output logic [STRIDE_W-1:0] fetch_stride,
  input  logic                fetch_done,
  output logic                ct_start,
  input  logic                ct_done,
  output logic                cs_start,
  input  logic                cs_done,
  output logic                ws_start,
  output logic [ADDR_W-1:0]   ws_addr,
  output logic [STRIDE_W-1:0] ws_stride,
  input  logic                ws_done,
  output logic                sp_buf_sel,
  output logic                sram_owner
);

  m2_state_e              state;
  m2_state_e              state_nxt;
  logic [NUM_UNITS-1:0]   launched;
  logic [NUM_UNITS-1:0]   flags;
  logic [NUM_UNITS-1:0]   flags_nxt;
  logic [NUM_UNITS-1:0]   done_vec;
  logic [NUM_UNITS-1:0]   launch_c;
  logic                   first_cyc;
  logic                   go;
  logic                   phase_done;
  logic                   gen_clear;
  logic [BLK_IDX_W-1:0]   blk_k;
  logic [ADDR_W-1:0]      f_addr_c;
  logic [STRIDE_W-1:0]    f_stride_c;
  logic [ADDR_W-1:0]      w_addr_c;
  logic [STRIDE_W-1:0]    w_stride_c;

  assign done_vec = {ws_done, cs_done, ct_done, fetch_done};

  // Dones on the launch cycle or from units outside the current phase are dropped.
  assign flags_nxt  = first_cyc ? '0 : (flags | (done_vec & launched));
  assign phase_done = (flags_nxt == launched);
  assign gen_clear  = go && (state_nxt == S_DONE);

  m2_block_addr_gen #(.OUT_SIDE(1'b0)) u_fetch_gen (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (gen_clear),
    .advance  (launch_c[U_FS]),
    .addr_c   (f_addr_c),
    .stride_c (f_stride_c)
  );

  m2_block_addr_gen #(.OUT_SIDE(1'b1)) u_write_gen (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (gen_clear),
    .advance  (launch_c[U_WS]),
    .addr_c   (w_addr_c),
    .stride_c (w_stride_c)
  );

  // Next state and the set of units launched on entry to it.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    launch_c  = '0;
    unique case (state)
      S_IDLE: if (Start) begin
        state_nxt      = S_LEAD_FS;
        go             = 1'b1;
        launch_c[U_FS] = 1'b1;
      end
      S_LEAD_FS: if (phase_done) begin
        state_nxt      = S_LEAD_CT;
        go             = 1'b1;
        launch_c[U_CT] = 1'b1;
      end
      S_LEAD_CT: if (phase_done) begin
        state_nxt      = S_PH_B;
        go             = 1'b1;
        launch_c[U_CS] = 1'b1;
        launch_c[U_FS] = (blk_k < BLK_IDX_W'(NUM_BLOCKS - 1));
      end
      S_PH_B: if (phase_done) begin
        go = 1'b1;
        if (blk_k == BLK_IDX_W'(NUM_BLOCKS - 1)) begin
          state_nxt      = S_LEAD_OUT_WS;
          launch_c[U_WS] = 1'b1;
        end else begin
          state_nxt      = S_PH_A;
          launch_c[U_CT] = 1'b1;
          launch_c[U_WS] = 1'b1;
        end
      end
      S_PH_A: if (phase_done) begin
        state_nxt      = S_PH_B;
        go             = 1'b1;
        launch_c[U_CS] = 1'b1;
        launch_c[U_FS] = (blk_k < BLK_IDX_W'(NUM_BLOCKS - 2));
      end
      S_LEAD_OUT_WS: if (phase_done) begin
        state_nxt = S_DONE;
        go        = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        go        = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_IDLE;
      launched     <= '0;
      flags        <= '0;
      first_cyc    <= 1'b0;
      blk_k        <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      fetch_start  <= 1'b0;
      ct_start     <= 1'b0;
      cs_start     <= 1'b0;
      ws_start     <= 1'b0;
      fetch_addr   <= '0;
      fetch_stride <= '0;
      ws_addr      <= '0;
      ws_stride    <= '0;
      sp_buf_sel   <= 1'b0;
      sram_owner   <= 1'b0;
    end else begin
      state       <= state_nxt;
      flags       <= flags_nxt;
      first_cyc   <= 1'b0;
      fetch_start <= launch_c[U_FS];
      ct_start    <= launch_c[U_CT];
      cs_start    <= launch_c[U_CS];
      ws_start    <= launch_c[U_WS];
      Done        <= go && (state_nxt == S_DONE);
      if (go) begin
        launched   <= launch_c;
        flags      <= '0;
        first_cyc  <= 1'b1;
        sram_owner <= (state_nxt == S_PH_A) || (state_nxt == S_LEAD_OUT_WS);
        if (state == S_IDLE) begin
          Busy  <= 1'b1;
          blk_k <= '0;
        end
        if (state == S_PH_A) blk_k <= blk_k + BLK_IDX_W'(1);
        if (state == S_DONE) Busy <= 1'b0;
      end
      if (launch_c[U_FS]) begin
        fetch_addr   <= f_addr_c;
        fetch_stride <= f_stride_c;
        sp_buf_sel   <= (state == S_IDLE) ? 1'b0 : ~sp_buf_sel;
      end
      if (launch_c[U_WS]) begin
        ws_addr   <= w_addr_c;
        ws_stride <= w_stride_c;
      end
    end
  end

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Bench for m2_block_scheduler: directed handshake corner cases plus full image passes
// with fixed and random unit latencies, checked against an image-geometry model.
module tb_m2_block_scheduler;

  localparam int NBLK = 2400;

  logic        Clock, Reset, Start;
  logic        Busy, Done;
  logic        fetch_start, fetch_done;
  logic [17:0] fetch_addr;
  logic [8:0]  fetch_stride;
  logic        ct_start, ct_done, cs_start, cs_done;
  logic        ws_start, ws_done;
  logic [17:0] ws_addr;
  logic [8:0]  ws_stride;
  logic        sp_buf_sel, sram_owner;

  int tests = 0;
  int fails = 0;

  m2_block_scheduler dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Busy(Busy), .Done(Done),
    .fetch_start(fetch_start), .fetch_addr(fetch_addr), .fetch_stride(fetch_stride),
    .fetch_done(fetch_done), .ct_start(ct_start), .ct_done(ct_done),
    .cs_start(cs_start), .cs_done(cs_done), .ws_start(ws_start), .ws_addr(ws_addr),
    .ws_stride(ws_stride), .ws_done(ws_done), .sp_buf_sel(sp_buf_sel), .sram_owner(sram_owner)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Image geometry: Y is 320x240, U/V are 160x240; coefficients one per word, pixels two per word.
  function automatic int exp_stride(input int k, input bit wr);
    int px;
    px = (k < 1200) ? 320 : 160;
    return wr ? px / 2 : px;
  endfunction

  function automatic int exp_addr(input int k, input bit wr);
    int pl, j, cols, brow, bcol, base;
    if (k < 1200)      begin pl = 0; j = k;        end
    else if (k < 1800) begin pl = 1; j = k - 1200; end
    else               begin pl = 2; j = k - 1800; end
    cols = (pl == 0) ? 40 : 20;
    brow = j / cols;
    bcol = j % cols;
    if (wr) base = (pl == 0) ? 0 : (pl == 1) ? 38400 : 57600;
    else    base = (pl == 0) ? 76800 : (pl == 1) ? 153600 : 192000;
    return base + brow * 8 * exp_stride(k, wr) + bcol * (wr ? 4 : 8);
  endfunction

  function automatic logic [61:0] all_outs();
    return {Busy, Done, fetch_start, ct_start, cs_start, ws_start, sp_buf_sel, sram_owner,
            fetch_addr, fetch_stride, ws_addr, ws_stride};
  endfunction

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0;
    fetch_done = 1'b0; ct_done = 1'b0; cs_done = 1'b0; ws_done = 1'b0;
    tick(); tick();
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    Reset = 1'b0;
    tick();
    tests++;
    if (Busy !== 1'b0 || fetch_start !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: busy=%b fetch_start=%b want 0 0", Busy, fetch_start);
    end
  endtask

  task automatic test_handshake();
    Start = 1'b1; tick(); Start = 1'b0;
    tests++;
    if (fetch_start !== 1'b1 || fetch_addr !== 18'd76800 || fetch_stride !== 9'd320 ||
        sram_owner !== 1'b0 || sp_buf_sel !== 1'b0 || Busy !== 1'b1) begin
      fails++; $display("FAIL first_fetch: fs=%b addr=%0d stride=%0d own=%b sel=%b busy=%b want 1 76800 320 0 0 1",
                        fetch_start, fetch_addr, fetch_stride, sram_owner, sp_buf_sel, Busy);
    end
    fetch_done = 1'b1; tick(); fetch_done = 1'b0;
    tests++;
    if (ct_start !== 1'b0 || fetch_start !== 1'b0) begin
      fails++; $display("FAIL launch_cycle_done: ct_start=%b fetch_start=%b want 0 0", ct_start, fetch_start);
    end
    fetch_done = 1'b1; tick(); fetch_done = 1'b0;
    tests++;
    if (ct_start !== 1'b1 || sram_owner !== 1'b0) begin
      fails++; $display("FAIL ct0_launch: ct_start=%b own=%b want 1 0", ct_start, sram_owner);
    end
    Start = 1'b1; tick(); Start = 1'b0;
    tests++;
    if (fetch_start !== 1'b0 || ct_start !== 1'b0 || Busy !== 1'b1) begin
      fails++; $display("FAIL start_while_busy: fs=%b ct=%b busy=%b want 0 0 1", fetch_start, ct_start, Busy);
    end
    ct_done = 1'b1; tick();
    tests++;
    if (cs_start !== 1'b1 || fetch_start !== 1'b1 || fetch_addr !== 18'd76808 ||
        sp_buf_sel !== 1'b1 || sram_owner !== 1'b0) begin
      fails++; $display("FAIL ph_b_launch: cs=%b fs=%b addr=%0d sel=%b own=%b want 1 1 76808 1 0",
                        cs_start, fetch_start, fetch_addr, sp_buf_sel, sram_owner);
    end
    ct_done = 1'b1; ws_done = 1'b1; tick(); ct_done = 1'b0; ws_done = 1'b0;
    tests++;
    if (ct_start !== 1'b0 || ws_start !== 1'b0) begin
      fails++; $display("FAIL stray_done: ct_start=%b ws_start=%b want 0 0", ct_start, ws_start);
    end
    cs_done = 1'b1; fetch_done = 1'b1; tick(); cs_done = 1'b0; fetch_done = 1'b0;
    tests++;
    if (ct_start !== 1'b1 || ws_start !== 1'b1 || ws_addr !== 18'd0 || ws_stride !== 9'd160 ||
        sram_owner !== 1'b1 || cs_start !== 1'b0 || fetch_start !== 1'b0) begin
      fails++; $display("FAIL same_cycle_done: ct=%b ws=%b waddr=%0d wstride=%0d own=%b cs=%b fs=%b want 1 1 0 160 1 0 0",
                        ct_start, ws_start, ws_addr, ws_stride, sram_owner, cs_start, fetch_start);
    end
    tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL reset_mid_pass: got %h want 0", all_outs());
    end
    ct_done = 1'b1; ws_done = 1'b1; tick(); ct_done = 1'b0; ws_done = 1'b0;
    tests++;
    if (Busy !== 1'b0 || ct_start !== 1'b0 || ws_start !== 1'b0 || fetch_start !== 1'b0) begin
      fails++; $display("FAIL idle_after_mid_reset: busy=%b ct=%b ws=%b fs=%b want 0 0 0 0",
                        Busy, ct_start, ws_start, fetch_start);
    end
    Start = 1'b1; tick(); Start = 1'b0;
    tests++;
    if (fetch_start !== 1'b1 || fetch_addr !== 18'd76800 || sp_buf_sel !== 1'b0) begin
      fails++; $display("FAIL restart_after_reset: fs=%b addr=%0d sel=%b want 1 76800 0",
                        fetch_start, fetch_addr, sp_buf_sel);
    end
    Reset = 1'b1; tick(); tick(); Reset = 1'b0; tick();
  endtask

  // Full image pass; units answer after a fixed 3 cycles or a random 1..4 cycles.
  task automatic test_full_pass(input bit rand_mode);
    int cnt[4];
    int fi, ci, ti, wi, lit, d;
    bit expect_adv, fired, seen_done, finished;
    logic any_start;
    foreach (cnt[u]) cnt[u] = 0;
    fi = 0; ci = 0; ti = 0; wi = 0;
    seen_done = 1'b0; finished = 1'b0;
    tick(); Start = 1'b1; tick(); Start = 1'b0;
    expect_adv = 1'b1;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      any_start = fetch_start | ct_start | cs_start | ws_start;
      if (seen_done) begin
        Start = 1'b0;
        tests++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
          fails++; $display("FAIL after_done: busy=%b done=%b want 0 0", Busy, Done);
        end
        finished = 1'b1;
        break;
      end
      tests++;
      if (Busy !== 1'b1) begin
        fails++; $display("FAIL busy cyc %0d: got %b want 1", cyc, Busy);
      end
      tests++;
      if ((any_start | Done) !== expect_adv) begin
        fails++; $display("FAIL advance cyc %0d: got %b want %b", cyc, any_start | Done, expect_adv);
      end
      tests++;
      if (any_start === 1'b1 && (cnt[0] | cnt[1] | cnt[2] | cnt[3]) != 0) begin
        fails++; $display("FAIL overlap cyc %0d: launch while units busy %0d %0d %0d %0d want idle",
                          cyc, cnt[0], cnt[1], cnt[2], cnt[3]);
      end
      if (fetch_start === 1'b1) begin
        tests++;
        if (fetch_addr !== 18'(exp_addr(fi, 1'b0)) || fetch_stride !== 9'(exp_stride(fi, 1'b0))) begin
          fails++; $display("FAIL fetch_addr blk %0d: got %0d/%0d want %0d/%0d", fi, fetch_addr,
                            fetch_stride, exp_addr(fi, 1'b0), exp_stride(fi, 1'b0));
        end
        tests++;
        if (sp_buf_sel !== fi[0] || sram_owner !== 1'b0) begin
          fails++; $display("FAIL fetch_ctl blk %0d: sel=%b own=%b want %b 0", fi, sp_buf_sel, sram_owner, fi[0]);
        end
        tests++;
        if ((fi == 0) ? (cs_start !== 1'b0) : (cs_start !== 1'b1 || ci != fi - 1)) begin
          fails++; $display("FAIL fetch_pair blk %0d: cs_start=%b cs_idx=%0d want %b %0d", fi, cs_start, ci,
                            fi != 0, fi - 1);
        end
        case (fi)
          0:       lit = 76800;
          1:       lit = 76808;
          40:      lit = 79360;
          1200:    lit = 153600;
          1800:    lit = 192000;
          2399:    lit = 229272;
          default: lit = -1;
        endcase
        if (lit >= 0) begin
          tests++;
          if (fetch_addr !== 18'(lit)) begin
            fails++; $display("FAIL fetch_spot blk %0d: got %0d want %0d", fi, fetch_addr, lit);
          end
        end
      end
      if (cs_start === 1'b1) begin
        tests++;
        if (fetch_start !== (ci < NBLK - 1) || ci + 1 != ti) begin
          fails++; $display("FAIL cs_pair blk %0d: fetch_start=%b ct_count=%0d want %b %0d", ci, fetch_start,
                            ti, ci < NBLK - 1, ci + 1);
        end
      end
      if (ct_start === 1'b1) begin
        tests++;
        if (ws_start !== (ti > 0) || ti != ci || (ti > 0 && wi != ti - 1)) begin
          fails++; $display("FAIL ct_pair blk %0d: ws_start=%b cs_count=%0d ws_idx=%0d want %b %0d %0d",
                            ti, ws_start, ci, wi, ti > 0, ti, ti - 1);
        end
      end
      if (ws_start === 1'b1) begin
        tests++;
        if (ws_addr !== 18'(exp_addr(wi, 1'b1)) || ws_stride !== 9'(exp_stride(wi, 1'b1)) ||
            sram_owner !== 1'b1) begin
          fails++; $display("FAIL ws_addr blk %0d: got %0d/%0d own=%b want %0d/%0d 1", wi, ws_addr, ws_stride,
                            sram_owner, exp_addr(wi, 1'b1), exp_stride(wi, 1'b1));
        end
        tests++;
        if (ct_start !== (wi < NBLK - 1)) begin
          fails++; $display("FAIL ws_pair blk %0d: ct_start=%b want %b", wi, ct_start, wi < NBLK - 1);
        end
        case (wi)
          0:       lit = 0;
          40:      lit = 1280;
          1200:    lit = 38400;
          1800:    lit = 57600;
          2399:    lit = 76236;
          default: lit = -1;
        endcase
        if (lit >= 0) begin
          tests++;
          if (ws_addr !== 18'(lit)) begin
            fails++; $display("FAIL ws_spot blk %0d: got %0d want %0d", wi, ws_addr, lit);
          end
        end
      end
      if (Done === 1'b1) begin
        tests++;
        if (fi != NBLK || ci != NBLK || ti != NBLK || wi != NBLK) begin
          fails++; $display("FAIL done_counts: fs=%0d cs=%0d ct=%0d ws=%0d want %0d each", fi, ci, ti, wi, NBLK);
        end
        seen_done = 1'b1;
      end
      if (fetch_start === 1'b1) fi++;
      if (cs_start === 1'b1)    ci++;
      if (ct_start === 1'b1)    ti++;
      if (ws_start === 1'b1)    wi++;
      // Retire outstanding units, then start timers for units launched this cycle.
      fetch_done = 1'b0; ct_done = 1'b0; cs_done = 1'b0; ws_done = 1'b0;
      fired = 1'b0;
      for (int u = 0; u < 4; u++) begin
        if (cnt[u] > 0) begin
          cnt[u]--;
          if (cnt[u] == 0) begin
            fired = 1'b1;
            case (u)
              0:       fetch_done = 1'b1;
              1:       ct_done = 1'b1;
              2:       cs_done = 1'b1;
              default: ws_done = 1'b1;
            endcase
          end
        end
      end
      d = rand_mode ? int'($urandom_range(1, 4)) : 3;
      if (fetch_start === 1'b1) cnt[0] = d;
      d = rand_mode ? int'($urandom_range(1, 4)) : 3;
      if (ct_start === 1'b1) cnt[1] = d;
      d = rand_mode ? int'($urandom_range(1, 4)) : 3;
      if (cs_start === 1'b1) cnt[2] = d;
      d = rand_mode ? int'($urandom_range(1, 4)) : 3;
      if (ws_start === 1'b1) cnt[3] = d;
      expect_adv = fired && (cnt[0] | cnt[1] | cnt[2] | cnt[3]) == 0;
      Start = rand_mode && !seen_done && ($urandom_range(0, 31) == 0);
      tick();
    end
    Start = 1'b0;
    fetch_done = 1'b0; ct_done = 1'b0; cs_done = 1'b0; ws_done = 1'b0;
    tests++;
    if (!finished) begin
      fails++; $display("FAIL pass_timeout: blocks written %0d want %0d within budget", wi, NBLK);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_full_pass(1'b0);
    test_full_pass(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
